// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;
   localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port not granted last time wins.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       valid,
   output logic       sel
);

   always_comb begin
      valid = |req;
      if (&req) begin
         sel = ~last;
      end else begin
         sel = req[1] ? P1 : P0;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Optional grant counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [AW-1:0]     p0_addr,
   input  logic [DW-1:0]     p0_wdata,
   output logic              p0_ack,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [AW-1:0]     p1_addr,
   input  logic [DW-1:0]     p1_wdata,
   output logic              p1_ack,
   output logic [DW-1:0]     rdata,
   output logic              busy,
`ifdef DMEM_ARB_STATS_EN
   output logic [STAT_W-1:0] p0_grants,
   output logic [STAT_W-1:0] p1_grants,
`endif
   output logic              mem_we,
   output logic [AW-1:0]     mem_a,
   output logic [DW-1:0]     mem_wd,
   input  logic [DW-1:0]     mem_rd
);

   arb_state_t    state_q, state_d;
   logic          gsel_q, gsel_d;
   logic          last_q;
   logic [DW-1:0] rdata_q;

   logic [1:0] ack_mask;
   logic [1:0] eff_req;
   logic       arb_valid;
   logic       arb_sel;
   logic       sel_we;

   // The port just acked is masked so a slow-to-drop req is not re-granted.
   assign ack_mask = (state_q == RESP) ? {gsel_q == P1, gsel_q == P0} : 2'b00;
   assign eff_req  = {p1_req, p0_req} & ~ack_mask;

   rr_arb2 u_arb (
      .req   (eff_req),
      .last  (last_q),
      .valid (arb_valid),
      .sel   (arb_sel)
   );

   always_comb begin
      state_d = state_q;
      gsel_d  = gsel_q;
      unique case (state_q)
         IDLE, RESP: begin
            if (arb_valid) begin
               state_d = ACCESS;
               gsel_d  = arb_sel;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS:  state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gsel_q  <= P0;
         last_q  <= P1;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         gsel_q  <= gsel_d;
         if (state_q == ACCESS) begin
            rdata_q <= mem_rd;
            last_q  <= gsel_q;
         end
      end
   end

   always_comb begin
      sel_we = (gsel_q == P1) ? p1_we    : p0_we;
      mem_a  = (gsel_q == P1) ? p1_addr  : p0_addr;
      mem_wd = (gsel_q == P1) ? p1_wdata : p0_wdata;
      // Gating with reset keeps a store from committing when reset lands in ACCESS.
      mem_we = (state_q == ACCESS) && sel_we && !reset;
      p0_ack = (state_q == RESP) && (gsel_q == P0);
      p1_ack = (state_q == RESP) && (gsel_q == P1);
      busy   = (state_q != IDLE);
      rdata  = rdata_q;
   end

`ifdef DMEM_ARB_STATS_EN
   logic [STAT_W-1:0] p0_grants_q, p0_grants_d;
   logic [STAT_W-1:0] p1_grants_q, p1_grants_d;
   logic              grant_en;

   assign grant_en = arb_valid && (state_q != ACCESS);

   always_comb begin
      p0_grants_d = p0_grants_q;
      p1_grants_d = p1_grants_q;
      if (grant_en && (arb_sel == P0) && (p0_grants_q != '1)) begin
         p0_grants_d = p0_grants_q + 1'b1;
      end
      if (grant_en && (arb_sel == P1) && (p1_grants_q != '1)) begin
         p1_grants_d = p1_grants_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p0_grants_q <= '0;
         p1_grants_q <= '0;
      end else begin
         p0_grants_q <= p0_grants_d;
         p1_grants_q <= p1_grants_d;
      end
   end

   assign p0_grants = p0_grants_q;
   assign p1_grants = p1_grants_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus multi-cycle corner sequences.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        p0_req = 1'b0, p0_we = 1'b0;
   logic [31:0] p0_addr = '0, p0_wdata = '0;
   logic        p1_req = 1'b0, p1_we = 1'b0;
   logic [31:0] p1_addr = '0, p1_wdata = '0;
   logic        p0_ack, p1_ack, busy, mem_we;
   logic [31:0] rdata, mem_a, mem_wd, mem_rd;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] p0_grants, p1_grants;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        port;
      logic        chk;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[7];

   logic [31:0] mem [0:63];
   logic [5:0]  widx;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .p0_req   (p0_req),
      .p0_we    (p0_we),
      .p0_addr  (p0_addr),
      .p0_wdata (p0_wdata),
      .p0_ack   (p0_ack),
      .p1_req   (p1_req),
      .p1_we    (p1_we),
      .p1_addr  (p1_addr),
      .p1_wdata (p1_wdata),
      .p1_ack   (p1_ack),
      .rdata    (rdata),
      .busy     (busy),
`ifdef DMEM_ARB_STATS_EN
      .p0_grants(p0_grants),
      .p1_grants(p1_grants),
`endif
      .mem_we   (mem_we),
      .mem_a    (mem_a),
      .mem_wd   (mem_wd),
      .mem_rd   (mem_rd)
   );

   // Word-indexed memory model with combinational read.
   assign widx   = mem_a[7:2];
   assign mem_rd = mem[widx];
   always @(posedge clk) if (mem_we) mem[widx] <= mem_wd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every ack must match the oldest expected completion.
   always @(negedge clk) begin
      if (p0_ack || p1_ack) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack: got p0_ack=%b p1_ack=%b expected none at %0t",
                     p0_ack, p1_ack, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("ack_port", {30'b0, p1_ack, p0_ack}, e.port ? 32'd2 : 32'd1);
            if (e.chk) check("sb_rdata", rdata, e.data);
         end
      end
   end

   task automatic push(input logic port, input logic chk, input logic [31:0] data);
      exp_t e;
      e.port = port;
      e.chk  = chk;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      p0_req = 1'b0;
      p1_req = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic drive(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
      if (port) begin
         p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
      end else begin
         p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
      end
   endtask

   // Single isolated access: req in cycle 0, ACCESS in cycle 1, ack in cycle 2.
   task automatic run_access(input logic port, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp);
      push(port, !we, exp);
      drive(port, we, addr, wdata);
      step();
      check("access_busy", {31'b0, busy}, 32'd1);
      check("access_noack", {30'b0, p1_ack, p0_ack}, 32'd0);
      check("access_we", {31'b0, mem_we}, {31'b0, we});
      check("access_addr", mem_a, addr);
      if (we) check("access_wd", mem_wd, wdata);
      step();
      check("resp_ack", {30'b0, p1_ack, p0_ack}, port ? 32'd2 : 32'd1);
      check("resp_we", {31'b0, mem_we}, 32'd0);
      p0_req = 1'b0;
      p1_req = 1'b0;
      step();
      check("after_idle", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b1, 32'h14, 32'h0BADF00D, 32'h0};
      vecs[3] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
      vecs[4] = '{1'b0, 1'b0, 32'h14, 32'h0,        32'h0BADF00D};
      vecs[5] = '{1'b1, 1'b1, 32'h13, 32'h55AA55AA, 32'h0};
      vecs[6] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'h55AA55AA};

      do_reset();
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_ack", {30'b0, p1_ack, p0_ack}, 32'd0);
      check("rst_we", {31'b0, mem_we}, 32'd0);
      check("rst_rdata", rdata, 32'd0);

      for (int i = 0; i < 7; i++) begin
         run_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
      end

      // Tie after reset: port 0 first, port 1 two cycles later, then port 0 again.
      do_reset();
      for (int r = 0; r < 2; r++) begin
         push(1'b0, 1'b1, 32'h55AA55AA);
         push(1'b1, 1'b1, 32'h0BADF00D);
         drive(1'b0, 1'b0, 32'h10, 32'h0);
         drive(1'b1, 1'b0, 32'h14, 32'h0);
         step();
         check("tie_first_addr", mem_a, 32'h10);
         step();
         check("tie_ack0", {30'b0, p1_ack, p0_ack}, 32'd1);
         p0_req = 1'b0;
         step();
         check("tie_second_addr", mem_a, 32'h14);
         step();
         check("tie_ack1", {30'b0, p1_ack, p0_ack}, 32'd2);
         p1_req = 1'b0;
         step();
         check("tie_idle", {31'b0, busy}, 32'd0);
      end

      // Continuous contention: acks every 2 cycles, strictly alternating.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         push(k[0], 1'b1, k[0] ? 32'h0BADF00D : 32'h55AA55AA);
      end
      drive(1'b0, 1'b0, 32'h10, 32'h0);
      drive(1'b1, 1'b0, 32'h14, 32'h0);
      for (int c = 1; c <= 16; c++) begin
         step();
         if (c % 2 == 0) begin
            check("alt_ack", {30'b0, p1_ack, p0_ack}, ((c / 2) % 2 == 1) ? 32'd1 : 32'd2);
         end else begin
            check("alt_gap", {30'b0, p1_ack, p0_ack}, 32'd0);
         end
         if (c == 16) begin
            p0_req = 1'b0;
            p1_req = 1'b0;
         end
      end
      step();
      check("alt_idle", {31'b0, busy}, 32'd0);

      // Reset during a port-1 store's ACCESS: no write, no ack.
      run_access(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0);
      drive(1'b1, 1'b1, 32'h20, 32'h12345678);
      step();
      check("rst_access_we_pre", {31'b0, mem_we}, 32'd1);
      reset = 1'b1;
      #1;
      check("rst_access_we_gated", {31'b0, mem_we}, 32'd0);
      step();
      reset  = 1'b0;
      p1_req = 1'b0;
      check("rst_access_busy", {31'b0, busy}, 32'd0);
      check("rst_access_ack", {30'b0, p1_ack, p0_ack}, 32'd0);
      step();
      check("rst_access_idle", {31'b0, busy}, 32'd0);
      run_access(1'b0, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D);

      // Port 0 holds req through its ack: no re-grant, back to IDLE.
      push(1'b0, 1'b1, 32'hCAFEF00D);
      drive(1'b0, 1'b0, 32'h20, 32'h0);
      step();
      step();
      check("slow_drop_ack", {30'b0, p1_ack, p0_ack}, 32'd1);
      step();
      check("slow_drop_idle", {31'b0, busy}, 32'd0);
      check("slow_drop_noack", {30'b0, p1_ack, p0_ack}, 32'd0);
      p0_req = 1'b0;
      step();
      check("slow_drop_still_idle", {31'b0, busy}, 32'd0);

`ifdef DMEM_ARB_STATS_EN
      do_reset();
      check("stats_rst0", {16'b0, p0_grants}, 32'd0);
      check("stats_rst1", {16'b0, p1_grants}, 32'd0);
      for (int k = 0; k < 3; k++) run_access(1'b0, 1'b0, 32'h10, 32'h0, 32'h55AA55AA);
      for (int k = 0; k < 5; k++) run_access(1'b1, 1'b0, 32'h14, 32'h0, 32'h0BADF00D);
      check("stats_p0", {16'b0, p0_grants}, 32'd3);
      check("stats_p1", {16'b0, p1_grants}, 32'd5);
      force dut.p0_grants_q = 16'hFFFF;
      step();
      release dut.p0_grants_q;
      run_access(1'b0, 1'b0, 32'h10, 32'h0, 32'h55AA55AA);
      check("stats_sat", {16'b0, p0_grants}, 32'h0000FFFF);
      check("stats_p1_hold", {16'b0, p1_grants}, 32'd5);
`endif

      step();
      check("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
